alu_exec_unit: RTL and testbench

//  Execute stage fed by alu_control: takes the 4-bit ALU_control code plus operands, computes the result, registers it.

---
 rtl/alu_exec_unit.sv | 170 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with single-cycle ops and iterative shifter
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out,
  output logic            busy
);

  // Shift amount width, plus one spare bit so SHIFT_STEP == XLEN still fits.
  localparam int SW = $clog2(XLEN);
  localparam int RW = SW + 1;
  localparam logic [RW-1:0] STEP_C = RW'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shkind_t;

  state_t          state_q;
  shkind_t         kind_q;
  shkind_t         kind_d;
  logic [XLEN-1:0] work_q;
  logic [XLEN-1:0] work_d;
  logic [RW-1:0]   rem_q;
  logic [RW-1:0]   rem_d;
  logic [RW-1:0]   step_d;
  logic [4:0]      rd_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic [4:0]      rd_out_q;

  logic            accept;
  logic            is_shift_op;
  logic [RW-1:0]   shamt_in;
  logic            start_shift;
  logic            shift_done;
  logic [XLEN-1:0] alu_res_d;

  // Handshake: a new request is taken only when idle and the output slot is free or draining now.
  assign in_ready    = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign is_shift_op = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign shamt_in    = {1'b0, op_b[SW-1:0]};
  assign start_shift = accept && is_shift_op && (shamt_in != '0);
  assign shift_done  = (state_q == S_SHIFT) && (rem_d == '0);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign rd_out    = rd_out_q;
  assign busy      = (state_q == S_SHIFT);

  // Single-cycle ALU; a shift op only lands here with shamt 0, which passes op_a through.
  always_comb begin
    alu_res_d = op_a + op_b;
    case (alu_ctrl)
      OP_ADD:  alu_res_d = op_a + op_b;
      OP_SUB:  alu_res_d = op_a - op_b;
      OP_AND:  alu_res_d = op_a & op_b;
      OP_OR:   alu_res_d = op_a | op_b;
      OP_XOR:  alu_res_d = op_a ^ op_b;
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_res_d = op_a;
      OP_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_res_d = op_a + op_b;
    endcase
  end

  // Decode the shift flavour to latch alongside the work register.
  always_comb begin
    kind_d = SH_LL;
    case (alu_ctrl)
      OP_SRL:  kind_d = SH_RL;
      OP_SRA:  kind_d = SH_RA;
      default: kind_d = SH_LL;
    endcase
  end

  // One shifter step: at most SHIFT_STEP bits; SRA keeps the original sign because the MSB never changes.
  always_comb begin
    step_d = (rem_q > STEP_C) ? STEP_C : rem_q;
    rem_d  = rem_q - step_d;
    case (kind_q)
      SH_RL:   work_d = work_q >> step_d;
      SH_RA:   work_d = $signed(work_q) >>> step_d;
      default: work_d = work_q << step_d;
    endcase
  end

  // Control FSM plus registered result slot; a result load on the drain edge overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      kind_q      <= SH_LL;
      work_q      <= '0;
      rem_q       <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rd_out_q    <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_shift) begin
            work_q  <= op_a;
            rem_q   <= shamt_in;
            kind_q  <= kind_d;
            rd_q    <= rd_in;
            state_q <= S_SHIFT;
          end else if (accept) begin
            result_q    <= alu_res_d;
            zero_q      <= (alu_res_d == '0);
            rd_out_q    <= rd_in;
            out_valid_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (shift_done) begin
            result_q    <= work_d;
            zero_q      <= (work_d == '0);
            rd_out_q    <= rd_q;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit (SHIFT_STEP 1 and 8)
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [3:0]  alu_ctrl [2];
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic [4:0]  rd_in [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] result [2];
  logic        zero [2];
  logic [4:0]  rd_out [2];
  logic        busy [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } item_t;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the architectural meaning of each code.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  // Extra cycles beyond the single-cycle path: ceil(shamt/step) for a real shift.
  function automatic int ref_delay(input int step, input logic [3:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((c == 4'd5 || c == 4'd6 || c == 4'd7) && sh != 0) return (sh + step - 1) / step;
    return 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int STEP = (g == 0) ? 1 : 8;
    item_t sb[$];
    int sh_a = 0;
    int sh_d = 0;

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(STEP)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .alu_ctrl  (alu_ctrl[g]),
      .op_a      (op_a[g]),
      .op_b      (op_b[g]),
      .rd_in     (rd_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .zero      (zero[g]),
      .rd_out    (rd_out[g]),
      .busy      (busy[g])
    );

    initial begin
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          sb.delete();
          sh_a = 0;
          sh_d = 0;
        end else begin
          automatic bit    ev = (sb.size() > 0) && (sb[0].due <= cyc);
          automatic bit    eb = (cyc >= sh_a) && (cyc < sh_d);
          automatic int    dly;
          automatic item_t it;
          chk($sformatf("i%0d out_valid", g), 32'(out_valid[g]), 32'(ev));
          chk($sformatf("i%0d busy", g), 32'(busy[g]), 32'(eb));
          chk($sformatf("i%0d in_ready", g), 32'(in_ready[g]), 32'(!eb && (!ev || out_ready[g])));
          if (ev) begin
            chk($sformatf("i%0d result", g), result[g], sb[0].res);
            chk($sformatf("i%0d rd_out", g), 32'(rd_out[g]), 32'(sb[0].rd));
            chk($sformatf("i%0d zero", g), 32'(zero[g]), 32'(sb[0].res == 32'd0));
            if (out_valid[g] && out_ready[g]) void'(sb.pop_front());
          end
          if (in_valid[g] && in_ready[g]) begin
            dly    = ref_delay(STEP, alu_ctrl[g], op_b[g]);
            it.res = ref_alu(alu_ctrl[g], op_a[g], op_b[g]);
            it.rd  = rd_in[g];
            it.due = cyc + 1 + dly;
            sb.push_back(it);
            if (dly > 0) begin
              sh_a = cyc + 1;
              sh_d = cyc + 1 + dly;
            end
          end
        end
      end
    end
  end

  // Present a request from posedge+#1 and hold it until accepted; returns at posedge+#1.
  task automatic drive(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int acc);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    alu_ctrl[i] = c;
    op_a[i]     = a;
    op_b[i]     = b;
    rd_in[i]    = rd;
    acc = -1;
    while (n < 300) begin
      @(negedge clk);
      if (in_ready[i]) break;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout i%0d actual=no_accept expected=accept", i);
    end else begin
      acc = cyc + 1;
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic run_lit(input int i, input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] er,
                         input logic ez, input int el, output int busy_cnt);
    int acc;
    int n;
    busy_cnt = 0;
    n = 0;
    drive(i, c, a, b, rd, acc);
    while (n < 200) begin
      @(negedge clk);
      if (out_valid[i]) break;
      if (busy[i]) begin
        busy_cnt++;
        chk({nm, "_in_ready_busy"}, 32'(in_ready[i]), 32'd0);
      end
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_out_valid expected=out_valid", nm);
    end else begin
      chk({nm, "_result"}, result[i], er);
      chk({nm, "_zero"}, 32'(zero[i]), 32'(ez));
      chk({nm, "_rd"}, 32'(rd_out[i]), 32'(rd));
      chk({nm, "_latency"}, 32'(cyc - acc + 1), 32'(el));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stream(input int i, input int nops);
    int acc;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < nops; k++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (k % 5 == 0) a = a | 32'h8000_0000;
      if (k % 7 == 0) a = 32'd0;
      if (k % 4 == 0) b = 32'($urandom_range(0, 3));
      drive(i, c, a, b, 5'($urandom_range(0, 31)), acc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int bc;
    bit d0;
    bit d1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      alu_ctrl[i]  = 4'd0;
      op_a[i]      = 32'd0;
      op_b[i]      = 32'd0;
      rd_in[i]     = 5'd0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_result", result[i], 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_rd_out", 32'(rd_out[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready0", 32'(in_ready[0]), 32'd1);
    chk("rel_in_ready1", 32'(in_ready[1]), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, SHIFT_STEP=1
    run_lit(0, "add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'h0000_0000, 1'b1, 1, bc);
    run_lit(0, "sub", 4'd1, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE, 1'b0, 1, bc);
    run_lit(0, "slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1, 1'b0, 1, bc);
    run_lit(0, "sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0, 1'b1, 1, bc);
    run_lit(0, "and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd7, 32'h0000_F000, 1'b0, 1, bc);
    run_lit(0, "or", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd8, 32'h0000_FFF0, 1'b0, 1, bc);
    run_lit(0, "xor", 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd9, 32'h0000_0FF0, 1'b0, 1, bc);
    run_lit(0, "sra4", 4'd7, 32'h8000_0000, 32'd4, 5'd10, 32'hF800_0000, 1'b0, 5, bc);
    chk("sra4_busy_cycles", 32'(bc), 32'd4);
    run_lit(0, "sll0", 4'd5, 32'h0000_1234, 32'd0, 5'd11, 32'h0000_1234, 1'b0, 1, bc);
    run_lit(0, "srl3", 4'd6, 32'h0000_0080, 32'h0000_0023, 5'd12, 32'h0000_0010, 1'b0, 4, bc);
    run_lit(0, "illegal_add", 4'd12, 32'd7, 32'd8, 5'd13, 32'd15, 1'b0, 1, bc);

    // Directed vectors, SHIFT_STEP=8
    run_lit(1, "s8_sra20", 4'd7, 32'h8000_0000, 32'd20, 5'd14, 32'hFFFF_F800, 1'b0, 4, bc);
    chk("s8_sra20_busy_cycles", 32'(bc), 32'd3);
    run_lit(1, "s8_sll31", 4'd5, 32'd1, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0, 5, bc);

    // Backpressure: second ADD accepted on the drain edge
    out_ready[0] = 1'b0;
    drive(0, 4'd0, 32'd10, 32'd20, 5'd1, acc);
    fork
      drive(0, 4'd0, 32'd3, 32'd4, 5'd2, acc);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
          chk("bp_hold_result", result[0], 32'd30);
          chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    @(negedge clk);
    chk("bp_second_result", result[0], 32'd7);
    chk("bp_second_rd", 32'(rd_out[0]), 32'd2);
    @(posedge clk);
    #1;

    // Reset in the middle of a shift
    drive(0, 4'd5, 32'd1, 32'd20, 5'd9, acc);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_result", result[0], 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 32'(in_ready[0]), 32'd1);
    repeat (25) @(negedge clk);
    chk("mid_no_stale_result", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1;

    // Random stream with random downstream stalls on both step sizes
    d0 = 1'b0;
    d1 = 1'b0;
    fork
      begin
        rand_stream(0, 50);
        d0 = 1'b1;
      end
      begin
        rand_stream(1, 50);
        d1 = 1'b1;
      end
      begin
        while (!(d0 && d1)) begin
          @(posedge clk);
          #1;
          out_ready[0] = 1'($urandom_range(0, 1));
          out_ready[1] = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("i0_all_delivered", 32'(g_inst[0].sb.size()), 32'd0);
    chk("i1_all_delivered", 32'(g_inst[1].sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
